// File: rtl/bram_to_axi_lite_if.sv
// axi_lite_channel: AXI-lite bus bundle (aw/w/b/ar/r) shared between an
// initiator (master modport) and a target (slave modport).
interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/bram_to_axi_lite.sv
// bram_to_axi_lite: turns a BRAM-style word-addressed request port into
// AXI-lite master transactions, one in flight, strictly in order.
// Optional: BRAM_TO_AXI_LITE_SKID_EN adds a one-entry request buffer so the
// next request can be accepted while the current one is still in flight.
module bram_to_axi_lite #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    BRAM_ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    axi_lite_channel.master            slave,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [DATA_WIDTH/8-1:0]    req_we,
    input  logic [BRAM_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_WIDTH-1:0]      resp_rdata,
    output logic                       resp_err
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, WRITE, BRESP, READ, RDATA, RESP} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [STRB_W-1:0]     we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  aw_done_q, w_done_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                       accept, start_go, start_wr;
    logic [STRB_W-1:0]          src_we;
    logic [BRAM_ADDR_WIDTH-1:0] src_addr;
    logic [DATA_WIDTH-1:0]      src_wdata;
    logic                       aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Word address -> byte address; the cast zero-extends or truncates, the add wraps.
    function automatic logic [ADDR_WIDTH-1:0] byte_addr(input logic [BRAM_ADDR_WIDTH-1:0] w);
        logic [BRAM_ADDR_WIDTH+LSB-1:0] b;
        b = {w, {LSB{1'b0}}};
        return ADDR_WIDTH'(b) + BASE_ADDR;
    endfunction

    assign aw_hs    = slave.awvalid & slave.awready;
    assign w_hs     = slave.wvalid  & slave.wready;
    assign b_hs     = slave.bvalid  & slave.bready;
    assign ar_hs    = slave.arvalid & slave.arready;
    assign r_hs     = slave.rvalid  & slave.rready;
    assign accept   = req_valid & req_ready;
    assign start_wr = |src_we;

`ifdef BRAM_TO_AXI_LITE_SKID_EN
    logic                       sk_vld_q;
    logic [STRB_W-1:0]          sk_we_q;
    logic [BRAM_ADDR_WIDTH-1:0] sk_addr_q;
    logic [DATA_WIDTH-1:0]      sk_wdata_q;
    logic                       slot;

    // A new transaction may start from IDLE or straight out of a completing RESP.
    assign slot      = (state_q == IDLE) | ((state_q == RESP) & resp_ready);
    assign req_ready = rstn & ~sk_vld_q;
    assign start_go  = slot & (sk_vld_q | accept);
    assign src_we    = sk_vld_q ? sk_we_q    : req_we;
    assign src_addr  = sk_vld_q ? sk_addr_q  : req_addr;
    assign src_wdata = sk_vld_q ? sk_wdata_q : req_wdata;

    // Buffer fills when a request arrives with no free slot, drains when it starts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sk_vld_q   <= 1'b0;
            sk_we_q    <= '0;
            sk_addr_q  <= '0;
            sk_wdata_q <= '0;
        end else if (accept & ~slot) begin
            sk_vld_q   <= 1'b1;
            sk_we_q    <= req_we;
            sk_addr_q  <= req_addr;
            sk_wdata_q <= req_wdata;
        end else if (slot & sk_vld_q) begin
            sk_vld_q   <= 1'b0;
        end
    end
`else
    // rstn gates req_ready so it reads 0 while reset is held.
    assign req_ready = rstn & (state_q == IDLE);
    assign start_go  = accept;
    assign src_we    = req_we;
    assign src_addr  = req_addr;
    assign src_wdata = req_wdata;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: all exits are taken on registered valids and sampled handshakes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_go) state_d = start_wr ? WRITE : READ;
            WRITE: if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = BRESP;
            BRESP: if (b_hs) state_d = RESP;
            READ:  if (ar_hs) state_d = RDATA;
            RDATA: if (r_hs) state_d = RESP;
            RESP:  if (resp_ready) state_d = start_go ? (start_wr ? WRITE : READ) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction registers, AW/W completion flags and latched response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q    <= '0;
            we_q      <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (start_go) begin
                addr_q  <= byte_addr(src_addr);
                we_q    <= src_we;
                wdata_q <= src_wdata;
            end
            aw_done_q <= start_go ? 1'b0 : (aw_done_q | aw_hs);
            w_done_q  <= start_go ? 1'b0 : (w_done_q | w_hs);
            if (b_hs) begin
                rdata_q <= '0;
                err_q   <= slave.bresp[1];
            end else if (r_hs) begin
                rdata_q <= slave.rdata;
                err_q   <= slave.rresp[1];
            end
        end
    end

    assign slave.awvalid = (state_q == WRITE) & ~aw_done_q;
    assign slave.wvalid  = (state_q == WRITE) & ~w_done_q;
    assign slave.bready  = (state_q == BRESP);
    assign slave.arvalid = (state_q == READ);
    assign slave.rready  = (state_q == RDATA);
    assign slave.awaddr  = addr_q;
    assign slave.araddr  = addr_q;
    assign slave.awprot  = 3'b000;
    assign slave.arprot  = 3'b000;
    assign slave.wdata   = wdata_q;
    assign slave.wstrb   = we_q;

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_bram_to_axi_lite.sv
// tb_bram_to_axi_lite: directed bench with a small configurable-latency AXI-lite slave.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bram_to_axi_lite;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ax ();

    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [3:0]  req_we;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    bram_to_axi_lite #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BRAM_ADDR_WIDTH(32), .BASE_ADDR(32'h8000_0000)
    ) dut (
        .clk(clk), .rstn(rstn), .slave(ax),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    int n_chk = 0;
    int n_err = 0;
    int tcyc  = 0;
    int lat;
    always @(posedge clk) tcyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Slave configuration and observation.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
    logic [31:0] rdata_v = 32'h0;
    bit          rd_mode = 1'b0;
    int          aw_c, w_c, ar_c;
    bit          aw_seen, w_seen, ar_seen, b_fire, r_fire;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0;
    int          aw_at, w_at;
    logic [31:0] cap_awaddr, cap_araddr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [2:0]  cap_awprot, cap_arprot;

    // Slave: ready after a programmable wait, one-cycle B/R after the address phase.
    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            ax.awready = 1'b0; ax.wready = 1'b0; ax.arready = 1'b0;
            ax.bvalid = 1'b0; ax.bresp = 2'b00;
            ax.rvalid = 1'b0; ax.rresp = 2'b00; ax.rdata = 32'h0;
            aw_c = 0; w_c = 0; ar_c = 0;
            aw_seen = 0; w_seen = 0; ar_seen = 0; b_fire = 0; r_fire = 0;
        end else begin
            if (b_fire) begin ax.bvalid = 1'b0; b_fire = 0; n_b++; end
            else if (!ax.bvalid && aw_seen && w_seen) begin
                ax.bvalid = 1'b1; ax.bresp = bresp_v; aw_seen = 0; w_seen = 0;
            end
            if (ax.bvalid && ax.bready) b_fire = 1;

            if (r_fire) begin ax.rvalid = 1'b0; r_fire = 0; end
            else if (!ax.rvalid && ar_seen) begin
                ax.rvalid = 1'b1; ax.rresp = rresp_v; ar_seen = 0;
                ax.rdata  = rd_mode ? {16'hCAFE, cap_araddr[15:0]} : rdata_v;
            end
            if (ax.rvalid && ax.rready) r_fire = 1;

            if (ax.awready) ax.awready = 1'b0;
            else if (ax.awvalid) begin
                if (aw_c >= aw_dly) begin
                    ax.awready = 1'b1; aw_seen = 1; aw_c = 0; n_aw++; aw_at = tcyc;
                    cap_awaddr = ax.awaddr; cap_awprot = ax.awprot;
                end else aw_c++;
            end

            if (ax.wready) ax.wready = 1'b0;
            else if (ax.wvalid) begin
                if (w_c >= w_dly) begin
                    ax.wready = 1'b1; w_seen = 1; w_c = 0; n_w++; w_at = tcyc;
                    cap_wdata = ax.wdata; cap_wstrb = ax.wstrb;
                end else w_c++;
            end

            if (ax.arready) ax.arready = 1'b0;
            else if (ax.arvalid) begin
                if (ar_c >= ar_dly) begin
                    ax.arready = 1'b1; ar_seen = 1; ar_c = 0; n_ar++;
                    cap_araddr = ax.araddr; cap_arprot = ax.arprot;
                end else ar_c++;
            end
        end
    end

    // Present one request and return on the falling edge after it is accepted.
    task automatic send(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        int t = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        if (!req_ready) chk("req_timeout", 32'd0, 32'd1);
        @(negedge clk);
        req_valid = 1'b0; req_we = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    endtask

    // Called one cycle after acceptance; lat counts cycles from the acceptance cycle.
    task automatic wait_resp(output int l);
        l = 1;
        while (!resp_valid && l < 200) begin @(negedge clk); l++; end
        if (!resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", tcyc);
        $fatal(1, "watchdog");
    end

    int nb0, naw0, nw0, nar0;

    initial begin
        req_valid = 1'b0; req_we = 4'h0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_awvalid", ax.awvalid, 0);
        chk("rst_wvalid", ax.wvalid, 0);
        chk("rst_bready", ax.bready, 0);
        chk("rst_arvalid", ax.arvalid, 0);
        chk("rst_rready", ax.rready, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        // Read word 0x10 with base 0x8000_0000.
        rdata_v = 32'hDEADBEEF; rresp_v = 2'b00;
        send(4'b0000, 32'h10, 32'h0);
        wait_resp(lat);
        chk("rd_latency", lat, 3);
        chk("rd_rdata", resp_rdata, 32'hDEADBEEF);
        chk("rd_err", resp_err, 0);
        ack();
        chk("rd_araddr", cap_araddr, 32'h8000_0040);
        chk("rd_arprot", cap_arprot, 3'b000);

        // Write, W accepted four cycles before AW.
        aw_dly = 4; w_dly = 0; bresp_v = 2'b00;
        nb0 = n_b; naw0 = n_aw; nw0 = n_w;
        send(4'b0101, 32'h3, 32'h11223344);
        wait_resp(lat);
        chk("wr_err", resp_err, 0);
        chk("wr_rdata_zero", resp_rdata, 0);
        ack();
        chk("wr_awaddr", cap_awaddr, 32'h8000_000C);
        chk("wr_wstrb", cap_wstrb, 4'b0101);
        chk("wr_wdata", cap_wdata, 32'h11223344);
        chk("wr_awprot", cap_awprot, 3'b000);
        chk("wr_w_before_aw", aw_at - w_at, 4);
        chk("wr_one_aw", n_aw - naw0, 1);
        chk("wr_one_w", n_w - nw0, 1);
        chk("wr_one_b", n_b - nb0, 1);

        // Read with DECERR.
        aw_dly = 0; rdata_v = 32'h0BADF00D; rresp_v = 2'b11;
        send(4'b0000, 32'h44, 32'h0);
        wait_resp(lat);
        chk("rd_decerr_err", resp_err, 1);
        chk("rd_decerr_data", resp_rdata, 32'h0BADF00D);
        ack();

        // Write with SLVERR, AW before W.
        w_dly = 3; bresp_v = 2'b10;
        send(4'b1111, 32'h8, 32'hA5A5A5A5);
        wait_resp(lat);
        chk("wr_slverr_err", resp_err, 1);
        chk("wr_slverr_rdata", resp_rdata, 0);
        ack();
        chk("wr2_awaddr", cap_awaddr, 32'h8000_0020);
        w_dly = 0; bresp_v = 2'b00;

        // EXOKAY counts as success; top word address wraps the byte address.
        rdata_v = 32'h12345678; rresp_v = 2'b01;
        send(4'b0000, 32'hFFFF_FFFF, 32'h0);
        wait_resp(lat);
        chk("rd_exokay_err", resp_err, 0);
        chk("rd_exokay_data", resp_rdata, 32'h12345678);
        ack();
        chk("rd_wrap_araddr", cap_araddr, 32'h7FFF_FFFC);
        rresp_v = 2'b00;

        // Response held for five cycles.
        rdata_v = 32'h13579BDF;
        send(4'b0000, 32'h20, 32'h0);
        wait_resp(lat);
        nar0 = n_ar;
`ifndef BRAM_TO_AXI_LITE_SKID_EN
        req_valid = 1'b1; req_we = 4'h0; req_addr = 32'h21; req_wdata = 32'h0;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, 32'h13579BDF);
            chk("hold_arvalid", ax.arvalid, 0);
`ifdef BRAM_TO_AXI_LITE_SKID_EN
            chk("hold_req_ready", req_ready, 1);
`else
            chk("hold_req_ready", req_ready, 0);
`endif
        end
        chk("hold_no_ar", n_ar - nar0, 0);
        ack();
`ifndef BRAM_TO_AXI_LITE_SKID_EN
        rdata_v = 32'h2468ACE0;
        send(4'b0000, 32'h21, 32'h0);
        wait_resp(lat);
        chk("queued_rdata", resp_rdata, 32'h2468ACE0);
        ack();
        chk("queued_araddr", cap_araddr, 32'h8000_0084);
`endif

        // Reset while AW/W are pending.
        aw_dly = 50; w_dly = 50;
        nb0 = n_b;
        send(4'b1111, 32'h7, 32'h55);
        @(negedge clk);
        chk("mid_awvalid", ax.awvalid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_awvalid", ax.awvalid, 0);
        chk("arst_wvalid", ax.wvalid, 0);
        chk("arst_arvalid", ax.arvalid, 0);
        chk("arst_bready", ax.bready, 0);
        chk("arst_rready", ax.rready, 0);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_req_ready", req_ready, 0);
        @(negedge clk);
        aw_dly = 0; w_dly = 0;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_resp_valid", resp_valid, 0);
        rdata_v = 32'hFACE0001;
        send(4'b0000, 32'h5, 32'h0);
        wait_resp(lat);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_rdata", resp_rdata, 32'hFACE0001);
        chk("post_rst_err", resp_err, 0);
        ack();
        chk("post_rst_araddr", cap_araddr, 32'h8000_0014);
        chk("post_rst_no_b", n_b - nb0, 0);

`ifdef BRAM_TO_AXI_LITE_SKID_EN
        // Back-to-back reads; the second waits in the buffer.
        rd_mode = 1'b1; resp_ready = 1'b1;
        send(4'b0000, 32'h1, 32'h0);
        chk("skid_busy_arvalid", ax.arvalid, 1);
        chk("skid_busy_req_ready", req_ready, 1);
        send(4'b0000, 32'h2, 32'h0);
        wait_resp(lat);
        chk("skid_first_rdata", resp_rdata, 32'hCAFE0004);
        @(negedge clk);
        chk("skid_no_bubble_arvalid", ax.arvalid, 1);
        chk("skid_second_araddr", ax.araddr, 32'h8000_0008);
        chk("skid_first_done", resp_valid, 0);
        wait_resp(lat);
        chk("skid_second_rdata", resp_rdata, 32'hCAFE0008);
        @(negedge clk);
        resp_ready = 1'b0; rd_mode = 1'b0;
        chk("skid_drained", req_ready, 1);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
